// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between the pipeline control and the RV32M mul/div unit.
interface ex_muldiv_unit_if;
  logic        pipeline_flush;
  logic        md_req;
  logic [2:0]  md_func3;
  logic [31:0] md_op1;
  logic [31:0] md_op2;
  logic        md_stall;
  logic        md_done;
  logic [31:0] md_result;

  modport master (
    output pipeline_flush, md_req, md_func3, md_op1, md_op2,
    input  md_stall, md_done, md_result
  );

  modport slave (
    input  pipeline_flush, md_req, md_func3, md_op1, md_op2,
    output md_stall, md_done, md_result
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: single-cycle 33x33 multiply,
// radix-2 restoring divide (32 iterations), divide corner cases resolved
// at issue. Stalls the front end until the result is presented.
module ex_muldiv_unit (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_unit_if.slave   md
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, next_state;
  logic [31:0] op1_q, op2_q;
  logic [1:0]  func3_q;   // bit 2 is implied by the MUL/DIV state
  logic [31:0] rem_q, quo_q;
  logic [4:0]  count_q;
  logic [31:0] result_q;
  logic        done_q;

  // Issue-time decode of divide corner cases, taken from the live inputs.
  logic        in_signed, div_zero, div_ovf, special;
  logic [31:0] special_result;

  always_comb begin
    in_signed      = ~md.md_func3[0];
    div_zero       = (md.md_op2 == '0);
    div_ovf        = in_signed && (md.md_op1 == 32'h8000_0000) && (md.md_op2 == '1);
    special        = md.md_func3[2] & (div_zero | div_ovf);
    special_result = '0;
    if (div_zero)
      special_result = md.md_func3[1] ? md.md_op1 : 32'hFFFF_FFFF;
    else if (div_ovf)
      special_result = md.md_func3[1] ? 32'h0 : 32'h8000_0000;
  end

  // Multiply: operands extended to 33 bits so all four variants share one signed multiplier.
  logic               sx1, sx2;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] product;
  logic [31:0]        mul_result;

  always_comb begin
    sx1        = (func3_q == 2'b01) || (func3_q == 2'b10);
    sx2        = (func3_q == 2'b01);
    mul_a      = {sx1 & op1_q[31], op1_q};
    mul_b      = {sx2 & op2_q[31], op2_q};
    // Only the low 64 bits of the 66-bit product are ever selected.
    product    = 64'(mul_a) * 64'(mul_b);
    mul_result = (func3_q == 2'b00) ? product[31:0] : product[63:32];
  end

  // One restoring-divide step on magnitudes plus the final sign fix-up.
  logic        div_signed, op1_neg, op2_neg;
  logic [31:0] dividend, divisor;
  logic [32:0] trial, diff;
  logic        ge;
  logic [31:0] rem_next, quo_next, q_fix, r_fix, div_result;

  always_comb begin
    div_signed = ~func3_q[0];
    op1_neg    = div_signed & op1_q[31];
    op2_neg    = div_signed & op2_q[31];
    dividend   = op1_neg ? -op1_q : op1_q;
    divisor    = op2_neg ? -op2_q : op2_q;
    // 33-bit trial keeps the compare exact when an unsigned divisor has bit 31 set.
    trial      = {rem_q, dividend[count_q]};
    diff       = trial - {1'b0, divisor};
    ge         = (trial >= {1'b0, divisor});
    rem_next   = ge ? diff[31:0] : trial[31:0];
    quo_next   = quo_q;
    quo_next[count_q] = ge;
    q_fix      = (op1_neg ^ op2_neg) ? -quo_next : quo_next;
    r_fix      = op1_neg ? -rem_next : rem_next;
    div_result = func3_q[1] ? r_fix : q_fix;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state and stall; flush overrides everything.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (md.md_req) begin
        if (special)              next_state = S_DONE;
        else if (md.md_func3[2])  next_state = S_DIV;
        else                      next_state = S_MUL;
      end
      S_MUL:  next_state = md.md_req ? S_DONE : S_IDLE;
      S_DIV:  if (!md.md_req)           next_state = S_IDLE;
              else if (count_q == 5'd0) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (md.pipeline_flush) next_state = S_IDLE;
    // Held low during reset so the stall releases together with the async state reset.
    md.md_stall = md.md_req & (state != S_DONE) & ~md.pipeline_flush & ~rst;
  end

  // Operand latch, iteration registers and registered result/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q    <= '0;
      op2_q    <= '0;
      func3_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (next_state == S_DONE);
      case (state)
        S_IDLE: if (next_state != S_IDLE) begin
          op1_q   <= md.md_op1;
          op2_q   <= md.md_op2;
          func3_q <= md.md_func3[1:0];
          rem_q   <= '0;
          quo_q   <= '0;
          count_q <= 5'd31;
          if (next_state == S_DONE) result_q <= special_result;
        end
        S_MUL: if (next_state == S_DONE) result_q <= mul_result;
        S_DIV: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          count_q <= count_q - 5'd1;
          if (next_state == S_DONE) result_q <= div_result;
        end
        default: ;
      endcase
    end
  end

  assign md.md_done   = done_q;
  assign md.md_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: table of hand-computed vectors plus
// operand-hold, back-to-back, flush and async-reset sequences.
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res;

  ex_muldiv_unit_if mif();

  ex_muldiv_unit dut (.clk(clk), .rst(rst), .md(mif.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Starts an op at the current negedge (cycle 0) and follows it until md_done.
  // Leaves md_req high so a following call issues back-to-back.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm,
                        input bit scramble);
    int got;
    bit stall_ok;
    logic [31:0] res;
    got = -1;
    stall_ok = 1'b1;
    res = '0;
    mif.md_req   = 1'b1;
    mif.md_func3 = f;
    mif.md_op1   = a;
    mif.md_op2   = b;
    for (int c = 0; c <= lat + 2 && got < 0; c++) begin
      if (scramble && c >= 5 && c <= 20) begin
        mif.md_op1 = $urandom;
        mif.md_op2 = $urandom;
      end
      #1;
      if (mif.md_done === 1'b1) begin
        got = c;
        res = mif.md_result;
        if (mif.md_stall !== 1'b0) stall_ok = 1'b0;
      end else if (mif.md_stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
      @(negedge clk);
    end
    check({nm, "_latency"}, got, lat);
    check({nm, "_stall"}, {31'b0, stall_ok}, 32'd1);
    check({nm, "_result"}, res, exp);
    last_res = exp;
  endtask

  task automatic idle_cycle(input string nm);
    mif.md_req = 1'b0;
    #1;
    check({nm, "_done_pulse"}, {31'b0, mif.md_done}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 2};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 2};
    vecs[3]  = '{3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 2};
    vecs[4]  = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000006, 2};
    vecs[5]  = '{3'b001, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 2};
    vecs[6]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[7]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[8]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[9]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[10] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[11] = '{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33};
    vecs[12] = '{3'b101, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 33};
    vecs[13] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[14] = '{3'b111, 32'd5,        32'd0,        32'd5,        1};
    vecs[15] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[16] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[17] = '{3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 33};
    vecs[18] = '{3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 2};
    vecs[19] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2};
    vecs[20] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
    vecs[21] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
    vecs[22] = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[23] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[24] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};

    rst = 1'b1;
    mif.pipeline_flush = 1'b0;
    mif.md_req   = 1'b0;
    mif.md_func3 = '0;
    mif.md_op1   = '0;
    mif.md_op2   = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_done",   {31'b0, mif.md_done},  32'd0);
    check("reset_stall",  {31'b0, mif.md_stall}, 32'd0);
    check("reset_result", mif.md_result,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i), 1'b0);
      idle_cycle($sformatf("vec%0d", i));
    end

    // Forwarded operands change mid-divide; latched copies must be used.
    run_op(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "hold_div", 1'b1);
    idle_cycle("hold_div");

    // MUL then DIVU with no gap.
    run_op(3'b000, 32'd6, 32'd7, 32'd42, 2, "b2b_mul", 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "b2b_divu", 1'b0);
    idle_cycle("b2b_divu");

    // Flush at DIV cycle 10; a new op must then start from IDLE.
    mif.md_req   = 1'b1;
    mif.md_func3 = 3'b100;
    mif.md_op1   = 32'd1000;
    mif.md_op2   = 32'd3;
    repeat (10) @(negedge clk);
    mif.pipeline_flush = 1'b1;
    #1;
    check("flush_stall",  {31'b0, mif.md_stall}, 32'd0);
    check("flush_done",   {31'b0, mif.md_done},  32'd0);
    check("flush_result", mif.md_result,         last_res);
    @(negedge clk);
    mif.pipeline_flush = 1'b0;
    #1;
    check("post_flush_result", mif.md_result, last_res);
    run_op(3'b111, 32'd1000, 32'd3, 32'd1, 33, "after_flush", 1'b0);
    idle_cycle("after_flush");

    // Async reset at DIV cycle 15.
    mif.md_req   = 1'b1;
    mif.md_func3 = 3'b101;
    mif.md_op1   = 32'd999;
    mif.md_op2   = 32'd10;
    repeat (15) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_stall",  {31'b0, mif.md_stall}, 32'd0);
    check("arst_done",   {31'b0, mif.md_done},  32'd0);
    check("arst_result", mif.md_result,         32'd0);
    @(negedge clk);
    mif.md_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    run_op(3'b101, 32'd999, 32'd10, 32'd99, 33, "after_reset", 1'b0);
    idle_cycle("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the EX stage. It consumes the operands and function fields held in the ID/EX pipeline register, and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. While the result is pending it asserts a stall that freezes the front-end pipeline registers. It presents the 32-bit result to the EX result mux in the cycle the instruction leaves EX.

## Interface
Parameters:
- none (XLEN fixed at 32; divider is radix-2, 1 quotient bit per cycle)

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- pipeline_flush  in  1  aborts any in-flight operation
- md_req  in  1  level; EX holds a valid M-extension op (opcode 0110011, func7 0000001, not invalid)
- md_func3  in  3  RV32M func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- md_op1  in  32  rs1 value after forwarding
- md_op2  in  32  rs2 value after forwarding
- md_stall  out  1  combinational; hold PC, IF/ID, ID/EX, and insert a bubble into EX/MEM
- md_done  out  1  registered; result valid this cycle
- md_result  out  32  registered result; meaningful only when md_done=1

## Operation
- States: IDLE, MUL, DIV, DONE. Encoding is free.
- Reset: state=IDLE, md_done=0, md_result=0, and all internal operand, product, quotient, remainder and counter registers are 0.
- IDLE, md_req=1:
  - Latch md_op1, md_op2 and md_func3.
  - func3[2]=0: go to MUL.
  - func3[2]=1 with a special case: go directly to DONE with the fixed result.
  - Otherwise: go to DIV with count=31.
- MUL:
  - Form a 66-bit signed product of 33-bit extended operands.
  - op1 is sign-extended for MULH and MULHSU; op2 is sign-extended for MULH only. Otherwise zero-extend.
  - Result: MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32].
  - Register the result and go to DONE.
- DIV (restoring):
  - Operands are converted to magnitudes for DIV/REM, and left raw for DIVU/REMU.
  - Each cycle: rem = {rem[30:0], dividend[count]}; if rem ≥ divisor, subtract and set q[count]=1.
  - Decrement count. When count reaches 0, apply the sign fix-up and go to DONE.
  - Sign fix-up: quotient is negated when the operand signs differ (signed ops only). Remainder takes the sign of the dividend.
- Special cases, decided in IDLE:
  - Divisor=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op1.
  - DIV with op1=0x80000000 and op2=0xFFFFFFFF: → 0x80000000.
  - REM with the same operands: → 0.
- DONE: md_done=1 and md_result holds the value. Return to IDLE unconditionally on the next edge.
- md_stall = md_req & (state != DONE) & ~pipeline_flush.
- pipeline_flush=1 in any state: next state IDLE, md_done=0 next cycle. Partial results are discarded and md_result is not updated.
- md_req dropping while in MUL or DIV is treated as an abort: return to IDLE.
- Operand inputs are ignored outside IDLE. Forwarded values may change during the stall; the latched copies are used.

## Timing
- Cycle numbering: cycle 0 is the first cycle md_req=1 in IDLE.
- MUL*:
  - Cycles 0–1: stall=1.
  - Cycle 2: DONE, stall=0, and the instruction advances at the end of cycle 2.
  - Total: 3 cycles in EX.
- DIV* normal:
  - Cycles 0–32: stall=1 (1 latch cycle + 32 iterations).
  - Cycle 33: DONE. Total: 34 cycles.
- DIV* special case: cycle 0 stall=1, cycle 1 DONE. Total: 2 cycles.
- Back-to-back M-ops:
  - The cycle after DONE the state is IDLE. If md_req=1 (new instruction), that is cycle 0 of the new op.
  - There is no dead cycle between them.
- md_done is never 1 for two consecutive cycles.
- Reset asserted mid-operation forces IDLE immediately, asynchronously. md_stall drops in the same cycle.

## Test plan
- MUL, MULH, MULHU:
  - op1=0xFFFFFFFF, op2=0x00000002.
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHU → 0x00000001.
  - md_done at cycle 2 and stall high exactly in cycles 0–1.
- MULHSU with op1=0x80000000, op2=0x80000000 → 0xC0000000.
- DIV and REM with op1=-7 (0xFFFFFFF9), op2=2:
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - md_done at cycle 33. Also check DIVU 100/7 → 14 and REMU 100/7 → 2.
- Special cases, each with md_done at cycle 1:
  - DIV by 0 with op1=5 → 0xFFFFFFFF; REMU by 0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Operand hold: change md_op1/md_op2 during DIV cycles 5–20 → result unchanged.
- Back-to-back and abort:
  - MUL immediately followed by DIVU: second op starts the cycle after the first DONE.
  - Assert pipeline_flush at DIV cycle 10 → IDLE next cycle, md_done stays 0, and md_stall is 0 during the flush cycle.
  - Assert rst at DIV cycle 15 → all outputs 0 immediately.
